// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the single-port memory bus arbiter: FSM states, grant owner,
// registered bus request layout and the fetch NOP returned on a watchdog abort.
package mem_bus_arbiter_pkg;

  localparam int unsigned ARB_ADDR_W = 20;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_IF   = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } gnt_t;

  typedef struct packed {
    logic                  We;
    logic [ARB_ADDR_W-1:0] Addr;
    logic [31:0]           Wdata;
    logic [3:0]            Be;
  } mem_req_t;

  function automatic mem_req_t fetch_req(input logic [ARB_ADDR_W-1:0] addr);
    mem_req_t r;
    r.We    = 1'b0;
    r.Addr  = addr;
    r.Wdata = '0;
    r.Be    = '1;
    return r;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Pipeline-side (IF and MEM ports) and memory-side signals of the bus arbiter.
// slave = arbiter view; master = the surrounding pipeline and memory.
interface mem_bus_arbiter_if #(
  parameter int unsigned ADDR_W = 20
) ();
  logic              If_Req;
  logic [ADDR_W-1:0] If_Addr;
  logic              If_Kill;
  logic [31:0]       If_Rdata;
  logic              If_Valid;
  logic              If_Stall;

  logic              D_Req;
  logic              D_We;
  logic [ADDR_W-1:0] D_Addr;
  logic [31:0]       D_Wdata;
  logic [3:0]        D_Be;
  logic [31:0]       D_Rdata;
  logic              D_Valid;
  logic              D_Stall;

  logic              Bus_Req;
  logic              Bus_We;
  logic [ADDR_W-1:0] Bus_Addr;
  logic [31:0]       Bus_Wdata;
  logic [3:0]        Bus_Be;
  logic              Bus_Ack;
  logic [31:0]       Bus_Rdata;
  logic              Bus_Err;

  modport slave (
    input  If_Req, If_Addr, If_Kill,
    output If_Rdata, If_Valid, If_Stall,
    input  D_Req, D_We, D_Addr, D_Wdata, D_Be,
    output D_Rdata, D_Valid, D_Stall,
    output Bus_Req, Bus_We, Bus_Addr, Bus_Wdata, Bus_Be, Bus_Err,
    input  Bus_Ack, Bus_Rdata
  );

  modport master (
    output If_Req, If_Addr, If_Kill,
    input  If_Rdata, If_Valid, If_Stall,
    output D_Req, D_We, D_Addr, D_Wdata, D_Be,
    input  D_Rdata, D_Valid, D_Stall,
    input  Bus_Req, Bus_We, Bus_Addr, Bus_Wdata, Bus_Be, Bus_Err,
    output Bus_Ack, Bus_Rdata
  );
endinterface

// File: rtl/mem_bus_arbiter_watchdog.sv
// arb_watchdog: counts cycles spent in a bus transfer and flags the
// TIMEOUT_CYC-th cycle without Bus_Ack. Cleared whenever the arbiter is idle.
module arb_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic Busy,
  input  logic Ack,
  output logic Expire
);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)     cnt <= '0;
    else if (!Busy) cnt <= '0;
    else            cnt <= cnt + 1'b1;
  end

  assign Expire = Busy & ~Ack & (cnt == CNT_W'(TIMEOUT_CYC - 1));
endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory bus between instruction fetch and the
// MEM-stage load/store port. Define ARB_TIMEOUT_EN to build the bus-ack watchdog.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W      = ARB_ADDR_W,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic             Clk,
  input  logic             Rst_n,
  mem_bus_arbiter_if.slave bus
);
  if (ADDR_W != ARB_ADDR_W) begin : g_addr_w_check
    $error("ADDR_W must equal ARB_ADDR_W of mem_bus_arbiter_pkg");
  end
  if (TIMEOUT_CYC < 2) begin : g_timeout_check
    $error("TIMEOUT_CYC must be at least 2");
  end

  arb_state_t state, state_nxt;
  gnt_t       last_gnt, last_gnt_nxt;
  mem_req_t   req_q;
  logic       bus_req_q, kill_seen;
  logic       if_ok, d_ok, grant_if, grant_d;
  logic       xfer_busy, expire, done, if_done, d_done;
  logic       if_valid_q, d_valid_q;
  logic [31:0] if_rdata_q, d_rdata_q;

  // A port whose Valid is pulsing this cycle has been served; its still-high
  // Req must not be re-granted.
  assign if_ok     = bus.If_Req & ~bus.If_Kill & ~if_valid_q;
  assign d_ok      = bus.D_Req & ~d_valid_q;
  assign xfer_busy = (state != ARB_IDLE);

`ifdef ARB_TIMEOUT_EN
  logic err_q;

  arb_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
    .Clk    (Clk),
    .Rst_n  (Rst_n),
    .Busy   (xfer_busy),
    .Ack    (bus.Bus_Ack),
    .Expire (expire)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) err_q <= 1'b0;
    else        err_q <= expire;
  end
  assign bus.Bus_Err = err_q;
`else
  assign expire      = 1'b0;
  assign bus.Bus_Err = 1'b0;
`endif

  assign done    = xfer_busy & (bus.Bus_Ack | expire);
  assign if_done = (state == ARB_IF) & done & ~kill_seen & ~bus.If_Kill;
  assign d_done  = (state == ARB_DATA) & done;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= ARB_IDLE;
      last_gnt <= GNT_IF;
    end else begin
      state    <= state_nxt;
      last_gnt <= last_gnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    last_gnt_nxt = last_gnt;
    grant_if     = 1'b0;
    grant_d      = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        if (if_ok && d_ok) begin
          grant_d  = (last_gnt == GNT_IF);
          grant_if = (last_gnt == GNT_D);
        end else begin
          grant_if = if_ok;
          grant_d  = d_ok;
        end
        if (grant_d) begin
          state_nxt    = ARB_DATA;
          last_gnt_nxt = GNT_D;
        end else if (grant_if) begin
          state_nxt    = ARB_IF;
          last_gnt_nxt = GNT_IF;
        end
      end
      ARB_IF, ARB_DATA: begin
        if (done) state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      bus_req_q <= 1'b0;
      req_q     <= '0;
    end else if (grant_d) begin
      bus_req_q <= 1'b1;
      req_q     <= '{We: bus.D_We, Addr: bus.D_Addr, Wdata: bus.D_Wdata, Be: bus.D_Be};
    end else if (grant_if) begin
      bus_req_q <= 1'b1;
      req_q     <= fetch_req(bus.If_Addr);
    end else if (done) begin
      bus_req_q <= 1'b0;
      req_q     <= '0;
    end
  end

  // A kill seen at any point of the fetch suppresses its completion.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)                             kill_seen <= 1'b0;
    else if (grant_if)                      kill_seen <= 1'b0;
    else if (state == ARB_IF && bus.If_Kill) kill_seen <= 1'b1;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if_valid_q <= if_done;
      d_valid_q  <= d_done;
      if (if_done) if_rdata_q <= bus.Bus_Ack ? bus.Bus_Rdata : NOP_INSTR;
      if (d_done) begin
        if (!bus.Bus_Ack)    d_rdata_q <= '0;
        else if (!req_q.We) d_rdata_q <= bus.Bus_Rdata;
      end
    end
  end

  assign bus.Bus_Req   = bus_req_q;
  assign bus.Bus_We    = req_q.We;
  assign bus.Bus_Addr  = req_q.Addr;
  assign bus.Bus_Wdata = req_q.Wdata;
  assign bus.Bus_Be    = req_q.Be;

  assign bus.If_Valid = if_valid_q;
  assign bus.If_Rdata = if_rdata_q;
  assign bus.If_Stall = bus.If_Req & ~if_valid_q;
  assign bus.D_Valid  = d_valid_q;
  assign bus.D_Rdata  = d_rdata_q;
  assign bus.D_Stall  = bus.D_Req & ~d_valid_q;
endmodule
